// File: rtl/rotary_onehot_decoder_pkg.sv
// -----------------------------------------------------------------------------
// rotary_pkg
// Shared types and helpers for the rotary one-hot decoder.
//   rot_state_e  : decoder FSM states (INIT, TRACK, FAULT)
//   onehot_t     : decoded index plus a flag that says the word was one-hot
//   onehot_idx() : 8-bit word -> {valid, 3-bit index}
//   rot_delta()  : (to - from) mod 8
// -----------------------------------------------------------------------------
package rotary_pkg;

  localparam int ROT_POSITIONS = 8;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } rot_state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } onehot_t;

  // valid is set only when exactly one bit is high; idx is then its position.
  function automatic onehot_t onehot_idx(input logic [ROT_POSITIONS-1:0] word);
    onehot_t     r;
    int unsigned ones;
    r.valid = 1'b0;
    r.idx   = 3'd0;
    ones    = 0;
    for (int i = 0; i < ROT_POSITIONS; i++) begin
      if (word[i]) begin
        ones++;
        r.idx = 3'(i);
      end
    end
    r.valid = (ones == 1);
    return r;
  endfunction

  // Three-bit subtraction wraps, which is exactly mod-8 arithmetic.
  function automatic logic [2:0] rot_delta(input logic [2:0] to_idx,
                                           input logic [2:0] from_idx);
    return to_idx - from_idx;
  endfunction

endpackage

// File: rtl/rotary_onehot_decoder_debounce.sv
// -----------------------------------------------------------------------------
// rotary_debounce
// Candidate register plus saturating stability counter. A value is accepted
// once it has been sampled unchanged long enough; accept is a one-cycle
// registered strobe, and dout holds the accepted value while accept is high.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   din    : raw input word
//   dout   : candidate word (the accepted value when accept is high)
//   accept : one-cycle strobe, registered
// Parameters: DEBOUNCE (stable cycles, 0 = immediate), WIDTH (data width)
// -----------------------------------------------------------------------------
module rotary_debounce #(
  parameter int DEBOUNCE = 4,
  parameter int WIDTH    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             accept
);

  localparam int CNT_W = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_q;
  logic             accept_d;
  logic             same;

  always_comb begin
    same   = (din == cand_q);
    cand_d = din;
    if (!same) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // The strobe fires only on the transition into CNT_MAX, so a value that
  // stays stable is accepted once and never repeated.
  if (DEBOUNCE == 0) begin : g_immediate
    assign accept_d = ~same;
  end else begin : g_counted
    assign accept_d = same && (cnt_q == CNT_W'(DEBOUNCE - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      accept_q <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      accept_q <= accept_d;
    end
  end

  assign dout   = cand_q;
  assign accept = accept_q;

endmodule

// File: rtl/rotary_onehot_decoder.sv
// -----------------------------------------------------------------------------
// rotary_onehot_decoder
// Decodes an active-low 8-position one-hot rotary word into a registered
// position, one-cycle CW/CCW step pulses, a wrapping signed step accumulator
// and a one-cycle fault pulse.
// Ports:
//   clk_49m       : 49.152 MHz system clock
//   reset         : asynchronous active-low reset
//   rotary_n[7:0] : rotary word, bit i low = position i
//   enable        : when low, position/pos_valid/FSM still track but
//                   step_ccw/step_cw/fault stay low and step_acc holds
//   position[2:0] : last accepted valid position
//   pos_valid     : a valid position is currently held
//   step_ccw      : one-cycle pulse, index +1 mod 8
//   step_cw       : one-cycle pulse, index -1 mod 8
//   step_acc      : ACC_W-bit signed step count (+1 CCW, -1 CW), wraps
//   fault         : one-cycle pulse on invalid word or multi-position jump
//   step_interval : (only with ROTARY_INTERVAL_EN) cycles between the two
//                   most recent step pulses, saturating at 0xFFFF
// Optional feature macro: ROTARY_INTERVAL_EN
// -----------------------------------------------------------------------------
module rotary_onehot_decoder
  import rotary_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int ACC_W    = 8
) (
  input  logic             clk_49m,
  input  logic             reset,
  input  logic [7:0]       rotary_n,
  input  logic             enable,
  output logic [2:0]       position,
  output logic             pos_valid,
  output logic             step_ccw,
  output logic             step_cw,
  output logic [ACC_W-1:0] step_acc,
  output logic             fault
`ifdef ROTARY_INTERVAL_EN
  ,
  output logic [15:0]      step_interval
`endif
);

  logic [ROT_POSITIONS-1:0] raw;
  logic [ROT_POSITIONS-1:0] word_acc;
  logic                     accept;
  onehot_t                  oh;
  logic [2:0]               delta;

  rot_state_e       state_q, state_d;
  logic [2:0]       position_q, position_d;
  logic             pos_valid_q, pos_valid_d;
  logic             step_ccw_q, step_ccw_d;
  logic             step_cw_q, step_cw_d;
  logic [ACC_W-1:0] step_acc_q, step_acc_d;
  logic             fault_q, fault_d;

  for (genvar gi = 0; gi < ROT_POSITIONS; gi++) begin : g_invert
    assign raw[gi] = ~rotary_n[gi];
  end

  rotary_debounce #(
    .DEBOUNCE(DEBOUNCE),
    .WIDTH   (ROT_POSITIONS)
  ) u_debounce (
    .clk   (clk_49m),
    .rst_n (reset),
    .din   (raw),
    .dout  (word_acc),
    .accept(accept)
  );

  always_comb begin
    oh    = onehot_idx(word_acc);
    delta = rot_delta(oh.idx, position_q);
  end

  // State register
  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        INIT:    if (oh.valid)  state_d = TRACK;
        TRACK:   if (!oh.valid) state_d = FAULT;
        FAULT:   if (oh.valid)  state_d = TRACK;
        default: state_d = INIT;
      endcase
    end
  end

  // Output logic; pulses are gated by enable, position tracking is not.
  always_comb begin
    position_d  = position_q;
    pos_valid_d = pos_valid_q;
    step_ccw_d  = 1'b0;
    step_cw_d   = 1'b0;
    step_acc_d  = step_acc_q;
    fault_d     = 1'b0;
    if (accept) begin
      case (state_q)
        INIT, FAULT: begin
          if (oh.valid) begin
            position_d  = oh.idx;
            pos_valid_d = 1'b1;
          end
        end
        TRACK: begin
          if (oh.valid) begin
            position_d = oh.idx;
            case (delta)
              3'd0: ;
              3'd1: begin
                step_ccw_d = enable;
                if (enable) step_acc_d = step_acc_q + ACC_W'(1);
              end
              3'd7: begin
                step_cw_d = enable;
                if (enable) step_acc_d = step_acc_q - ACC_W'(1);
              end
              // Jump of 2..6 positions: report and resync to the new index.
              default: fault_d = enable;
            endcase
          end else begin
            fault_d     = enable;
            pos_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      position_q  <= 3'd0;
      pos_valid_q <= 1'b0;
      step_ccw_q  <= 1'b0;
      step_cw_q   <= 1'b0;
      step_acc_q  <= '0;
      fault_q     <= 1'b0;
    end else begin
      position_q  <= position_d;
      pos_valid_q <= pos_valid_d;
      step_ccw_q  <= step_ccw_d;
      step_cw_q   <= step_cw_d;
      step_acc_q  <= step_acc_d;
      fault_q     <= fault_d;
    end
  end

  assign position  = position_q;
  assign pos_valid = pos_valid_q;
  assign step_ccw  = step_ccw_q;
  assign step_cw   = step_cw_q;
  assign step_acc  = step_acc_q;
  assign fault     = fault_q;

`ifdef ROTARY_INTERVAL_EN
  logic [15:0] ivl_cnt_q, ivl_cnt_d;
  logic [15:0] step_interval_q, step_interval_d;
  logic [15:0] ivl_next;

  // ivl_next is the count as it would be after this edge, so the latched
  // value equals the number of cycles between consecutive step pulses.
  always_comb begin
    ivl_next        = (ivl_cnt_q == 16'hFFFF) ? 16'hFFFF : ivl_cnt_q + 16'd1;
    ivl_cnt_d       = ivl_next;
    step_interval_d = step_interval_q;
    if (step_ccw_d || step_cw_d) begin
      step_interval_d = ivl_next;
      ivl_cnt_d       = 16'd0;
    end else if (fault_d) begin
      ivl_cnt_d = 16'd0;
    end
  end

  always_ff @(posedge clk_49m or negedge reset) begin
    if (!reset) begin
      ivl_cnt_q       <= 16'd0;
      step_interval_q <= 16'hFFFF;
    end else begin
      ivl_cnt_q       <= ivl_cnt_d;
      step_interval_q <= step_interval_d;
    end
  end

  assign step_interval = step_interval_q;
`endif

endmodule

// File: tb/tb_rotary_onehot_decoder.sv
module tb_rotary_onehot_decoder;

  logic       clk_49m;
  logic       reset;
  logic [7:0] rotary_n;
  logic       enable;
  logic [2:0] position;
  logic       pos_valid;
  logic       step_ccw;
  logic       step_cw;
  logic [7:0] step_acc;
  logic       fault;
`ifdef ROTARY_INTERVAL_EN
  logic [15:0] step_interval;
`endif

  int total = 0;
  int bad   = 0;
  int ccw_seen, cw_seen, fault_seen, excl_viol;

  rotary_onehot_decoder #(.DEBOUNCE(4), .ACC_W(8)) dut (
    .clk_49m  (clk_49m),
    .reset    (reset),
    .rotary_n (rotary_n),
    .enable   (enable),
    .position (position),
    .pos_valid(pos_valid),
    .step_ccw (step_ccw),
    .step_cw  (step_cw),
    .step_acc (step_acc),
    .fault    (fault)
`ifdef ROTARY_INTERVAL_EN
    ,
    .step_interval(step_interval)
`endif
  );

  initial clk_49m = 1'b0;
  always #5 clk_49m = ~clk_49m;

  // Pulse monitor on the inactive edge.
  always @(negedge clk_49m) begin
    if (reset) begin
      ccw_seen   += int'(step_ccw);
      cw_seen    += int'(step_cw);
      fault_seen += int'(fault);
      if (int'(step_ccw) + int'(step_cw) + int'(fault) > 1) excl_viol++;
    end
  end

  task automatic clear_counts();
    ccw_seen = 0; cw_seen = 0; fault_seen = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk_49m); #1;
    reset = 1'b0; rotary_n = 8'hFF;
    repeat (3) @(posedge clk_49m);
    @(negedge clk_49m); reset = 1'b1;
  endtask

  task automatic hold(input logic [7:0] val, input int n);
    @(posedge clk_49m); #1;
    rotary_n = val;
    repeat (n) @(posedge clk_49m);
    #1;
  endtask

  task automatic test_reset();
    excl_viol = 0;
    enable = 1'b1; rotary_n = 8'hFF; reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    total++; if ({position, pos_valid, step_ccw, step_cw, fault} !== 7'd0 || step_acc !== 8'd0) begin
      bad++; $display("FAIL reset_outputs got pos=%0d v=%0b ccw=%0b cw=%0b f=%0b acc=%0h exp all 0",
                      position, pos_valid, step_ccw, step_cw, fault, step_acc);
    end
    repeat (3) @(posedge clk_49m);
    @(negedge clk_49m); reset = 1'b1;
    clear_counts();
    @(posedge clk_49m); #1 rotary_n = 8'hFE;
    repeat (5) @(posedge clk_49m); #1;   // edge E0+4
    total++; if (pos_valid !== 1'b0) begin
      bad++; $display("FAIL latency_early pos_valid=%0b exp=0", pos_valid);
    end
    @(posedge clk_49m); #1;              // edge E0+5
    total++; if (pos_valid !== 1'b1 || position !== 3'd0) begin
      bad++; $display("FAIL latency_accept pos_valid=%0b pos=%0d exp 1/0", pos_valid, position);
    end
    repeat (5) @(posedge clk_49m); #1;
    total++; if (ccw_seen + cw_seen + fault_seen !== 0) begin
      bad++; $display("FAIL init_no_pulse pulses=%0d exp=0", ccw_seen + cw_seen + fault_seen);
    end
    $display("test_reset: position=%0d pos_valid=%0b", position, pos_valid);
  endtask

  task automatic test_ccw_fault();
    clear_counts();
    hold(8'hFD, 8);
    total++; if (ccw_seen !== 1 || position !== 3'd1) begin
      bad++; $display("FAIL ccw_first ccw=%0d pos=%0d exp 1/1", ccw_seen, position);
    end
    hold(8'hFB, 8);
    hold(8'h7F, 8);
    total++; if (ccw_seen !== 2 || cw_seen !== 0 || fault_seen !== 1) begin
      bad++; $display("FAIL ccw_fault_pulses ccw=%0d cw=%0d f=%0d exp 2/0/1", ccw_seen, cw_seen, fault_seen);
    end
    total++; if (position !== 3'd7 || pos_valid !== 1'b1 || step_acc !== 8'd2) begin
      bad++; $display("FAIL ccw_fault_state pos=%0d v=%0b acc=%0h exp 7/1/02", position, pos_valid, step_acc);
    end
    $display("test_ccw_fault: position=%0d step_acc=%0h", position, step_acc);
  endtask

  task automatic test_cw();
    apply_reset();
    hold(8'hFE, 8);
    clear_counts();
    hold(8'h7F, 8);
    total++; if (cw_seen !== 1 || ccw_seen !== 0 || fault_seen !== 0) begin
      bad++; $display("FAIL cw_pulses cw=%0d ccw=%0d f=%0d exp 1/0/0", cw_seen, ccw_seen, fault_seen);
    end
    total++; if (position !== 3'd7 || step_acc !== 8'hFF) begin
      bad++; $display("FAIL cw_state pos=%0d acc=%0h exp 7/ff", position, step_acc);
    end
    $display("test_cw: position=%0d step_acc=%0h", position, step_acc);
  endtask

  task automatic test_glitch();
    apply_reset();
    hold(8'hF7, 8);
    clear_counts();
    @(posedge clk_49m); #1 rotary_n = 8'hEF;
    repeat (3) @(posedge clk_49m); #1 rotary_n = 8'hF7;
    repeat (10) @(posedge clk_49m); #1;
    total++; if (position !== 3'd3 || ccw_seen + cw_seen + fault_seen !== 0) begin
      bad++; $display("FAIL glitch pos=%0d pulses=%0d exp 3/0", position, ccw_seen + cw_seen + fault_seen);
    end
    hold(8'hFF, 8);
    total++; if (fault_seen !== 1 || pos_valid !== 1'b0 || position !== 3'd3) begin
      bad++; $display("FAIL invalid_fault f=%0d v=%0b pos=%0d exp 1/0/3", fault_seen, pos_valid, position);
    end
    hold(8'h00, 8);
    total++; if (fault_seen !== 1 || pos_valid !== 1'b0) begin
      bad++; $display("FAIL fault_state_quiet f=%0d v=%0b exp 1/0", fault_seen, pos_valid);
    end
    hold(8'hEF, 8);
    total++; if (pos_valid !== 1'b1 || position !== 3'd4 || ccw_seen !== 0 || fault_seen !== 1) begin
      bad++; $display("FAIL fault_recover v=%0b pos=%0d ccw=%0d f=%0d exp 1/4/0/1", pos_valid, position, ccw_seen, fault_seen);
    end
    $display("test_glitch: position=%0d pos_valid=%0b", position, pos_valid);
  endtask

  task automatic test_enable();
    clear_counts();
    enable = 1'b0;
    hold(8'hDF, 8);
    hold(8'hBF, 8);
    total++; if (ccw_seen + cw_seen + fault_seen !== 0 || step_acc !== 8'd0 || position !== 3'd6) begin
      bad++; $display("FAIL disabled pulses=%0d acc=%0h pos=%0d exp 0/00/6", ccw_seen + cw_seen + fault_seen, step_acc, position);
    end
    enable = 1'b1;
    hold(8'hDF, 8);
    total++; if (cw_seen !== 1 || ccw_seen !== 0 || step_acc !== 8'hFF || position !== 3'd5) begin
      bad++; $display("FAIL reenable cw=%0d ccw=%0d acc=%0h pos=%0d exp 1/0/ff/5", cw_seen, ccw_seen, step_acc, position);
    end
    $display("test_enable: position=%0d step_acc=%0h", position, step_acc);
  endtask

  task automatic test_init_invalid();
    apply_reset();
    clear_counts();
    hold(8'hFF, 8);
    hold(8'hFC, 8);
    total++; if (pos_valid !== 1'b0 || fault_seen !== 0) begin
      bad++; $display("FAIL init_invalid v=%0b f=%0d exp 0/0", pos_valid, fault_seen);
    end
    hold(8'hFB, 8);
    total++; if (pos_valid !== 1'b1 || position !== 3'd2 || ccw_seen + cw_seen !== 0) begin
      bad++; $display("FAIL init_accept v=%0b pos=%0d steps=%0d exp 1/2/0", pos_valid, position, ccw_seen + cw_seen);
    end
    $display("test_init_invalid: position=%0d pos_valid=%0b", position, pos_valid);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    hold(8'h7F, 8);
    clear_counts();
    hold(8'hFE, 5);
    hold(8'hFD, 5);
    hold(8'hFB, 5);
    repeat (8) @(posedge clk_49m); #1;
    total++; if (ccw_seen !== 3 || fault_seen !== 0 || step_acc !== 8'd3 || position !== 3'd2) begin
      bad++; $display("FAIL back_to_back ccw=%0d f=%0d acc=%0h pos=%0d exp 3/0/03/2", ccw_seen, fault_seen, step_acc, position);
    end
    total++; if (excl_viol !== 0) begin
      bad++; $display("FAIL exclusive overlaps=%0d exp=0", excl_viol);
    end
    $display("test_back_to_back: position=%0d step_acc=%0h", position, step_acc);
  endtask

`ifdef ROTARY_INTERVAL_EN
  task automatic test_interval();
    apply_reset();
    total++; if (step_interval !== 16'hFFFF) begin
      bad++; $display("FAIL interval_reset got=%0h exp=ffff", step_interval);
    end
    hold(8'hFE, 8);
    @(posedge clk_49m); #1 rotary_n = 8'hFD;
    repeat (100) @(posedge clk_49m); #1 rotary_n = 8'hFB;
    repeat (10) @(posedge clk_49m); #1;
    total++; if (step_interval !== 16'd100) begin
      bad++; $display("FAIL interval_100 got=%0d exp=100", step_interval);
    end
    repeat (70000) @(posedge clk_49m); #1 rotary_n = 8'hF7;
    repeat (10) @(posedge clk_49m); #1;
    total++; if (step_interval !== 16'hFFFF) begin
      bad++; $display("FAIL interval_sat got=%0h exp=ffff", step_interval);
    end
    $display("test_interval: step_interval=%0h", step_interval);
  endtask
`endif

  initial begin
    clear_counts();
    excl_viol = 0;
    test_reset();
    test_ccw_fault();
    test_cw();
    test_glitch();
    test_enable();
    test_init_invalid();
    test_back_to_back();
`ifdef ROTARY_INTERVAL_EN
    test_interval();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rotary_onehot_decoder.md
Name: rotary_onehot_decoder

Overview:
- Decodes an 8-position one-hot rotary word, as presented to the game board's rotary input port, into a registered 3-bit position, single-cycle CW/CCW step pulses, a signed step accumulator and a fault flag.
- One instance per player.
- Sits on the game side of the rotary path and is the decoder counterpart of the top-level rotary generator.
- Used for input-path self-checking and for the absolute-stick mapping feature.

Parameters:
- DEBOUNCE, 4, consecutive clk_49m cycles a new input value must stay stable before it is accepted (0 = accept on first sample).
- ACC_W, 8, width of the signed step accumulator.

Ports:
- clk_49m  input  1  system clock, 49.152 MHz.
- reset  input  1  asynchronous, active-low reset.
- rotary_n  input  8  rotary word, active-low one-hot (bit i low = position i).
- enable  input  1  decode enable; when low, stable values are still tracked but no steps or faults are reported.
- position  output  3  index of the last accepted valid position.
- pos_valid  output  1  high once a valid one-hot position has been accepted.
- step_ccw  output  1  one-cycle pulse; position index advanced by +1 mod 8 (0x01->0x02, 0x80->0x01).
- step_cw  output  1  one-cycle pulse; position index moved by -1 mod 8.
- step_acc  output  ACC_W  signed two's-complement count: +1 per CCW, -1 per CW, wraps.
- fault  output  1  one-cycle pulse on an invalid word or a jump of more than one position.

Behaviour:
- Reset (async assert, sync release). All of the following are 0: position, pos_valid, step_ccw, step_cw, step_acc, fault, debounce counter, candidate register. FSM is in INIT.
- Input handling:
  - rotary_n is inverted to active-high raw[7:0] and registered once (candidate).
  - If raw != candidate: candidate <= raw and the counter clears.
  - Otherwise the counter increments, saturating at DEBOUNCE.
  - A value is accepted in the cycle the counter reaches DEBOUNCE. Acceptance is a single-cycle strobe, not repeated while the value stays stable.
- Classification of an accepted word:
  - ONEHOT(k): exactly one bit set.
  - INVALID: zero bits or more than one bit set.
- FSM states INIT, TRACK, FAULT:
  - INIT:
    - ONEHOT(k): position<=k, pos_valid<=1, go to TRACK. No step pulse.
    - INVALID: stay in INIT. No fault.
  - TRACK:
    - ONEHOT(k), delta=(k-position) mod 8. delta=0: nothing. delta=1: step_ccw, acc+1. delta=7: step_cw, acc-1. delta 2..6: fault pulse, position<=k, no step, stay in TRACK (resync).
    - INVALID: fault pulse, pos_valid<=0, go to FAULT. Position holds its last value.
  - FAULT:
    - ONEHOT(k): position<=k, pos_valid<=1, go to TRACK. No step pulse.
    - INVALID: stay in FAULT. No further fault pulse.
- Latency: outputs are registered. A new stable value first sampled at edge E0 produces its pulse and its position update at edge E0+DEBOUNCE+1, with a pulse width of exactly one cycle.
- enable=0:
  - Accepted values update position, pos_valid and the FSM.
  - step_ccw, step_cw and fault are forced low; step_acc holds.
  - Re-enabling does not replay steps missed while disabled.
- Step pulses and fault are mutually exclusive in any cycle.
- step_acc wraps modulo 2^ACC_W; no saturation.
- Input glitches shorter than DEBOUNCE+1 cycles are never accepted.
- Async reset mid-debounce discards the candidate and returns the FSM to INIT.

Optional Feature:
- Macro ROTARY_INTERVAL_EN.
- When defined, adds output step_interval [15:0]: the number of clk_49m cycles between the two most recent step pulses.
  - A free-running 16-bit counter clears on every step pulse; its pre-clear value is latched to step_interval. The counter saturates at 0xFFFF.
  - Reset value 0xFFFF. Faults and resyncs also clear the counter but do not latch it.
- When undefined, neither the port nor the counter exists and all other behaviour is identical.

Decomposition:
- Package rotary_pkg holds:
  - the FSM state enum (INIT, TRACK, FAULT);
  - localparam ROT_POSITIONS=8;
  - function onehot_idx (8-bit to 3-bit index plus a one-hot-valid flag);
  - function rot_delta (mod-8 difference).
- One sub-module, rotary_debounce: candidate register, saturating counter, single-cycle accept strobe, parameterised by DEBOUNCE and the data width.
- The decoder instantiates it once.

Test Plan:
- Reset then rotary_n=8'hFE stable for 10 cycles, DEBOUNCE=4 -> pos_valid=1 and position=0 at the 5th edge after first sample; no step pulse; fault=0.
- From position 0, apply 8'hFD, then 8'hFB, then 8'h7F (each held 8 cycles) -> step_ccw, step_ccw, fault (delta 5); position ends at 7; step_acc=2.
- From position 0, apply 8'h7F (held 8 cycles) -> single step_cw; position=7; step_acc=8'hFF.
- At position 3, a 3-cycle glitch to 8'hEF then back to 8'hF7 -> no pulse, position stays 3. Then 8'hFF held -> one fault pulse, pos_valid=0. Then 8'hEF -> pos_valid=1, position=4, no step.
- enable=0 during two CCW steps -> no pulses, step_acc unchanged, position advanced by 2. After enable=1, one CW step -> step_cw, step_acc decreases by 1.
- With ROTARY_INTERVAL_EN and two CCW steps whose pulses are 100 cycles apart -> step_interval=100. With no step for 70000 cycles, the next step latches 0xFFFF.
